mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit for the extended single-cycle CPU. It takes two 32-bit operands and `funct3` from decode and runs a 32-step shift-add multiply or a restoring divide. Its registered result feeds one input of the 32-bit 4:1 write-back select multiplexer. The control unit stalls PC and register-file write while `busy` is high, and selects this block's result on `done`.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_addsub33.sv | 19 +
 rtl/mdu_iter.sv | 178 +++++++++++++++++
 tb/tb_mdu_iter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and iteration count for the iterative RV32M multiply/divide unit.
package mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam int unsigned ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic op_a_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_addsub33.sv
// 33-bit add/subtract shared by the multiply add step and the divide trial subtract.
// Latency: combinational.
// Backpressure: none; pure datapath.
module mdu_addsub33 (
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic        sub,
   output logic [32:0] sum,
   output logic        cout
);

   logic [33:0] full;

   // Subtract as a + ~b + 1; cout = 1 means no borrow (a >= b).
   assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
   assign sum  = full[32:0];
   assign cout = full[33];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide on magnitudes.
// Latency: 34 clocks start->done (2 clocks for divide-by-zero and signed overflow).
// Backpressure: start is honoured only while idle; requests while busy are dropped.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] res
);

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [XLEN-1:0]     m_q, m_d;
   logic [2*XLEN-1:0]   work_q, work_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic                spec_q, spec_d;
   logic [XLEN-1:0]     forced_q, forced_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic                a_neg, b_neg;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic                div_zero, div_ovf;
   logic [XLEN-1:0]     forced_val;

   logic [XLEN:0]       as_a, as_b, as_sum;
   logic                as_sub, as_cout;
   logic [2*XLEN-1:0]   step;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo, rem, sel;

   // Operand decode on the live inputs; only used in the accepting IDLE cycle.
   assign a_neg = op_a_signed(funct3) & A[XLEN-1];
   assign b_neg = op_b_signed(funct3) & B[XLEN-1];
   assign abs_a = a_neg ? -A : A;
   assign abs_b = b_neg ? -B : B;

   assign div_zero = funct3[2] && (B == '0);
   assign div_ovf  = funct3[2] && !funct3[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

   always_comb begin
      forced_val = '0;
      if (div_zero) begin
         forced_val = funct3[1] ? A : '1;
      end else if (div_ovf) begin
         forced_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   // Divide sees {rem, quo[msb]} (the value after the left shift); multiply sees {0, acc}.
   assign as_sub = op_q[2];
   assign as_b   = {1'b0, m_q};
   assign as_a   = op_q[2] ? work_q[2*XLEN-1:XLEN-1] : {1'b0, work_q[2*XLEN-1:XLEN]};

   mdu_addsub33 u_addsub (
      .a    (as_a),
      .b    (as_b),
      .sub  (as_sub),
      .sum  (as_sum),
      .cout (as_cout)
   );

   always_comb begin
      step = work_q;
      if (op_q[2]) begin
         if (as_cout) begin
            step = {as_sum[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
         end else begin
            step = {work_q[2*XLEN-2:0], 1'b0};
         end
      end else if (work_q[0]) begin
         step = {as_sum, work_q[XLEN-1:1]};
      end else begin
         step = {1'b0, work_q[2*XLEN-1:1]};
      end
   end

   assign prod = neg_q ? -work_q : work_q;
   assign quo  = work_q[XLEN-1:0];
   assign rem  = work_q[2*XLEN-1:XLEN];

   always_comb begin
      sel = '0;
      case (op_q)
         OP_MUL:                         sel = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:   sel = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:                sel = neg_q  ? -quo : quo;
         OP_REM, OP_REMU:                sel = rneg_q ? -rem : rem;
         default:                        sel = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      m_d      = m_q;
      work_d   = work_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      spec_d   = spec_q;
      forced_d = forced_q;
      res_d    = res_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = funct3;
               cnt_d    = '0;
               neg_d    = a_neg ^ b_neg;
               rneg_d   = a_neg;
               m_d      = funct3[2] ? abs_b : abs_a;
               work_d   = {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
               spec_d   = div_zero | div_ovf;
               forced_d = forced_val;
               state_d  = (div_zero | div_ovf) ? ST_SIGN : ST_CALC;
            end
         end
         ST_CALC: begin
            work_d = step;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'(ITERS - 1)) begin
               state_d = ST_SIGN;
            end
         end
         ST_SIGN: begin
            res_d   = spec_q ? forced_q : sel;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         m_q      <= '0;
         work_q   <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         spec_q   <= 1'b0;
         forced_q <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         m_q      <= m_d;
         work_q   <= work_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         spec_q   <= spec_d;
         forced_q <= forced_d;
         res_q    <= res_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign res  = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed RV32M cases with literal results plus randomized ops against a 64-bit arithmetic model.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] res;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          exp_k    = -100;
   int          exp_last = -100;
   logic [31:0] exp_val  = '0;
   logic [31:0] exp_hold = '0;

   mdu_iter #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .A      (op_a),
      .B      (op_b),
      .busy   (busy),
      .done   (done),
      .res    (res)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, want);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      logic [63:0] p;
      logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Expected busy window / done cycle / held result, every cycle.
   always @(negedge clk) begin
      logic e_busy, e_done;
      if (rst) begin
         exp_hold = '0;
         chk("busy_in_reset", busy, 0);
         chk("done_in_reset", done, 0);
         chk("res_in_reset", res, 0);
      end else begin
         e_busy = (cyc >= exp_k) && (cyc <= exp_last);
         e_done = (cyc == exp_last);
         if (e_done) exp_hold = exp_val;
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("res", res, exp_hold);
      end
   end

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #2;
      start    = 1'b1;
      funct3   = f3;
      op_a     = a;
      op_b     = b;
      exp_val  = model(f3, a, b);
      exp_k    = cyc + 1;
      exp_last = exp_k + (is_special(f3, a, b) ? 1 : 33);
      @(posedge clk);
      #2;
      start  = 1'b0;
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
   endtask

   task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output int lat, output int bcnt);
      int n;
      issue(f3, a, b);
      r = '0;
      lat = -1;
      bcnt = 0;
      n = 0;
      while (n < 60) begin
         @(negedge clk);
         n++;
         if (busy) bcnt++;
         if (done) begin
            r = res;
            lat = cyc - exp_k + 1;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout op=%0d: got no done within 60 cycles, want done", f3);
      end
   endtask

   task automatic dir(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input int want_lat);
      logic [31:0] r;
      int lat, bcnt;
      run(f3, a, b, r, lat, bcnt);
      chk({name, "_res"}, r, want);
      chk({name, "_lat"}, 32'(lat), 32'(want_lat));
   endtask

   initial begin
      logic [31:0] r;
      int lat, bcnt, nd;
      rst = 1'b1;
      start = 1'b0;
      funct3 = '0;
      op_a = '0;
      op_b = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_res", res, 0);

      run(3'b000, 32'd7, 32'd6, r, lat, bcnt);
      chk("mul_res", r, 32'h0000_002A);
      chk("mul_lat", 32'(lat), 32'd34);
      chk("mul_busy_cycles", 32'(bcnt), 32'd34);

      dir("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      dir("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      dir("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
      dir("div",    3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      dir("rem",    3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34);
      dir("divu",   3'b101, 32'd100,       32'd7,         32'h0000_000E, 34);
      dir("remu",   3'b111, 32'd100,       32'd7,         32'h0000_0002, 34);
      dir("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
      dir("rem0",   3'b110, 32'd5,         32'd0,         32'h0000_0005, 2);
      dir("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      dir("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

      // Restarts with different operands while a MUL is in flight must be dropped.
      issue(3'b000, 32'h0001_2345, 32'h0000_0111);
      nd = 0;
      r = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            r = res;
         end
         @(posedge clk);
         #2;
         start  = (cyc == exp_k + 5) || (cyc == exp_k + 32);
         op_a   = $urandom;
         op_b   = $urandom;
         funct3 = 3'($urandom);
      end
      start = 1'b0;
      chk("ignore_res", r, 32'h0136_9C95);
      chk("ignore_done_count", 32'(nd), 32'd1);

      // Reset in the middle of a DIV.
      issue(3'b100, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      exp_k = -100;
      exp_last = -100;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_res", res, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      dir("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'h0000_0003, 34);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom);
         a = pick();
         b = pick();
         run(f3, a, b, r, lat, bcnt);
         chk("rand_res", r, model(f3, a, b));
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog");
   end

endmodule
